// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared constants for the RV32I multi-cycle controller.
//   - RV32I major opcodes recognised by the controller
//   - FSM state encodings (FETCH..TRAP), kept as plain localparams so older
//     tools and debug scripts that read state_o as a number keep working
//   - ALU operation class, ALU operand-select and write-back-select codes
//   - is_known_opcode(): true for every opcode the FSM sequences through EXEC
package rv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef logic [2:0] state_t;
    localparam state_t FETCH  = 3'd0;
    localparam state_t DECODE = 3'd1;
    localparam state_t EXEC   = 3'd2;
    localparam state_t MEM    = 3'd3;
    localparam state_t WB     = 3'd4;
    localparam state_t TRAP   = 3'd5;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASSB  = 2'b11;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    function automatic logic is_known_opcode(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_JAL)   || (op == OP_JALR) ||
               (op == OP_BRANCH) || (op == OP_LUI)  || (op == OP_AUIPC);
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_counter.sv
// rv_instret_counter: retired-instruction counter.
//   clk      in   system clock
//   reset    in   asynchronous active-high reset, clears the count
//   inc_i    in   add one this cycle
//   count_o  out  current count, wraps from all-ones to zero
module rv_instret_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Natural binary wrap gives the modulo-2^CNT_W behaviour for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control FSM.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables and mux selects, handshakes with a variable-latency
// unified memory and counts retired instructions.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   opcode              instr[6:0] from the IR, stable from DECODE to WB
//   stall               freeze the FSM, suppress all writes and retirement
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_we      memory request / write qualifier
//   mem_addr_sel        0 = PC, 1 = ALU result
//   ir_write_en, pc_write_en, branch_en, jump_en, reg_write_en  enables
//   alu_src_a/b, alu_op, wb_sel                                 mux codes
//   state_o             current state for debug
//   retired, instret    retire pulse and retired-instruction count
//   trap                (only with RV_CTRL_ILLEGAL_TRAP_EN) illegal opcode
// Optional feature macro: RV_CTRL_ILLEGAL_TRAP_EN. When defined an unlisted
// opcode parks the FSM in TRAP until reset instead of retiring as a NOP.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int         ALU_OP_W    = 2,
    parameter int         CNT_W       = 32,
    parameter logic [2:0] RESET_STATE = FETCH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                stall,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_write_en,
    output logic                pc_write_en,
    output logic                branch_en,
    output logic                jump_en,
    output logic                reg_write_en,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          wb_sel,
    output logic [2:0]          state_o,
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    output logic                trap,
`endif
    output logic                retired,
    output logic [CNT_W-1:0]    instret
);

    state_t     state_q;
    state_t     state_d;
    logic       memReq, memWe, addrSel;
    logic       irWe, pcWe, brEn, jmpEn, regWe, retire, trapRaw;
    logic [1:0] srcA, srcB, aluCode, wbSel;

    // State register; reset lands in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode of current state + opcode into controls and next state.
    // Stall is applied last so it overrides every transition and write
    // while leaving the memory request and mux selects as the state wants.
    always_comb begin
        state_d = state_q;
        memReq  = 1'b0;
        memWe   = 1'b0;
        addrSel = 1'b0;
        irWe    = 1'b0;
        pcWe    = 1'b0;
        brEn    = 1'b0;
        jmpEn   = 1'b0;
        regWe   = 1'b0;
        retire  = 1'b0;
        trapRaw = 1'b0;
        srcA    = SRCA_RS1;
        srcB    = SRCB_RS2;
        aluCode = ALU_ADD;
        wbSel   = WB_ALU;
        case (state_q)
            FETCH: begin
                memReq = 1'b1;
                srcA   = SRCA_PC;
                srcB   = SRCB_FOUR;
                if (mem_ready) begin
                    irWe    = 1'b1;
                    pcWe    = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (is_known_opcode(opcode)) begin
                    state_d = EXEC;
                end else begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    retire  = 1'b1;
                    state_d = FETCH;
`endif
                end
            end
            EXEC: begin
                state_d = WB;
                case (opcode)
                    OP_RTYPE: begin
                        aluCode = ALU_FUNCT;
                    end
                    OP_ITYPE: begin
                        srcB    = SRCB_IMM;
                        aluCode = ALU_FUNCT;
                    end
                    OP_LOAD, OP_STORE: begin
                        srcB    = SRCB_IMM;
                        state_d = MEM;
                    end
                    OP_BRANCH: begin
                        aluCode = ALU_BRANCH;
                        brEn    = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    OP_JAL, OP_AUIPC: begin
                        srcA = SRCA_PC;
                        srcB = SRCB_IMM;
                    end
                    OP_JALR: begin
                        srcB = SRCB_IMM;
                    end
                    OP_LUI: begin
                        srcA    = SRCA_ZERO;
                        srcB    = SRCB_IMM;
                        aluCode = ALU_PASSB;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                memReq  = 1'b1;
                addrSel = 1'b1;
                if (opcode == OP_STORE) begin
                    memWe = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end else if (mem_ready) begin
                    state_d = WB;
                end
            end
            WB: begin
                regWe   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
                if (opcode == OP_LOAD) begin
                    wbSel = WB_MEM;
                end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
                    wbSel = WB_PC;
                    pcWe  = 1'b1;
                    jmpEn = 1'b1;
                end
            end
            TRAP: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                trapRaw = 1'b1;
                state_d = TRAP;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
        if (stall) begin
            state_d = state_q;
            irWe    = 1'b0;
            pcWe    = 1'b0;
            brEn    = 1'b0;
            regWe   = 1'b0;
            retire  = 1'b0;
        end
    end

    // Outputs are forced quiet combinationally while reset is high, so an
    // in-flight memory request drops without waiting for a clock edge.
    assign mem_req      = memReq  & ~reset;
    assign mem_we       = memWe   & ~reset;
    assign mem_addr_sel = addrSel & ~reset;
    assign ir_write_en  = irWe    & ~reset;
    assign pc_write_en  = pcWe    & ~reset;
    assign branch_en    = brEn    & ~reset;
    assign jump_en      = jmpEn   & ~reset;
    assign reg_write_en = regWe   & ~reset;
    assign retired      = retire  & ~reset;
    assign alu_src_a    = reset ? 2'd0 : srcA;
    assign alu_src_b    = reset ? 2'd0 : srcB;
    assign wb_sel       = reset ? 2'd0 : wbSel;
    assign alu_op       = reset ? '0 : ALU_OP_W'(aluCode);
    assign state_o      = state_q;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    assign trap         = trapRaw & ~reset;
`endif

    rv_instret_counter #(
        .CNT_W(CNT_W)
    ) u_instret (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (retired),
        .count_o(instret)
    );

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Parametrised multi-cycle successor of the single-cycle RV32I opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with a variable-latency unified memory port and counts retired instructions.
- Sits between the instruction register (opcode source) and the datapath's enables and muxes.

Parameters:
- ALU_OP_W, 2, width of alu_op (00 add, 01 branch-compare, 10 funct-decoded, 11 pass-B for LUI).
- CNT_W, 32, width of the retired-instruction counter.
- RESET_STATE, 0, state encoding entered on reset (FETCH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward
- stall  in  1  freezes FSM; all write enables forced 0; mem_req held
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  request is a write
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write_en  out  1  latch the instruction register
- pc_write_en  out  1  unconditional PC write
- branch_en  out  1  PC write qualified by datapath compare result
- jump_en  out  1  PC source = ALU target (JAL/JALR)
- reg_write_en  out  1  register file write
- alu_src_a  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = const 4
- alu_op  out  ALU_OP_W  ALU operation class
- wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC (already +4)
- state_o  out  3  current state, for debug
- retired  out  1  one-cycle pulse when an instruction completes
- instret  out  CNT_W  retired-instruction count, wraps at 2^CNT_W

Behaviour:
- Reset: async, active-high; state = FETCH; instret = 0.
  - While reset is asserted, every enable, mem_req, retired, alu_op, and every mux select is 0.
  - Reset asserted mid-request drops mem_req immediately; a pending mem_ready is ignored.
- Outputs are combinational from state and opcode. Defaults are all 0 unless listed below.
- FETCH: mem_req=1, addr_sel=0, src_a=1, src_b=2, alu_op=00.
  - On mem_ready: ir_write_en=1, pc_write_en=1 (PC+4), go to DECODE.
  - Otherwise stay in FETCH, request held.
- DECODE: one cycle, no enables.
  - Goes to EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1101111, 1100111, 1100011, 0110111, 0010111.
  - An unlisted opcode is treated as a NOP: retired=1, go to FETCH.
- EXEC, per opcode:
  - R-type: src_b=0, alu_op=10, go to WB.
  - I-type: src_b=1, alu_op=10, go to WB.
  - Load and store: src_b=1, alu_op=00, go to MEM.
  - Branch: src_b=0, alu_op=01, branch_en=1, retired=1, go to FETCH.
  - JAL: src_a=1, src_b=1, go to WB.
  - JALR: src_a=0, src_b=1, go to WB.
  - LUI: src_a=2, src_b=1, alu_op=11, go to WB.
  - AUIPC: src_a=1, src_b=1, go to WB.
  - The ALU result is latched by the datapath ALU-out register every cycle.
- MEM: mem_req=1, addr_sel=1.
  - Store: mem_we=1; on mem_ready, retired=1, go to FETCH.
  - Load: on mem_ready, go to WB.
- WB: reg_write_en=1, retired=1, go to FETCH.
  - wb_sel = 1 for load, 2 for JAL/JALR, 0 otherwise.
  - JAL/JALR additionally assert pc_write_en=1 and jump_en=1.
- Stall:
  - Takes priority over every transition.
  - Write enables (ir, pc, branch, reg) and retired are forced to 0.
  - mem_req and mem_we retain their state values.
  - A mem_ready arriving during stall is ignored.
- Latency with zero-wait memory (mem_ready already high): branch 3, ALU/jump/store 4, load 5 cycles. Each memory wait cycle adds 1.
- instret increments on every retired pulse; it wraps from all-ones to 0.
- opcode is sampled combinationally and must stay stable from DECODE through WB; the IR guarantees this.

Optional Feature:
- Macro: RV_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unlisted opcode in DECODE enters TRAP (state 5). TRAP asserts output trap=1 with all enables 0 and does not retire.
  - TRAP is left only by reset.
  - Adds port trap (out, 1).
- Undefined: the port is absent and an unlisted opcode is a retired NOP, as specified above.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_BRANCH, OP_LUI, OP_AUIPC);
  - the state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5);
  - ALU-op, src_a, src_b and wb_sel codes.
- One sub-module, rv_instret_counter: a CNT_W counter with async reset and increment input.

Test Plan:
- R-type 0110011, mem_ready always 1 -> states 0,1,2,4,0; reg_write_en high only in WB; retired once; instret=1.
- Load 0000011, mem_ready held low for 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 for 4 cycles; then WB with wb_sel=1; total 8 cycles.
- Store 0100011 -> mem_we=1 in MEM; reg_write_en never asserted; retired on the mem_ready cycle.
- Branch 1100011 -> branch_en=1 and alu_op=01 in EXEC only; back in FETCH on cycle 4.
- Stall asserted 2 cycles during FETCH with mem_ready=1 -> ir_write_en=0, state stays FETCH, mem_req=1; advances the cycle after stall drops.
- Async reset pulse mid-MEM -> mem_req falls without a clock edge; state=0, instret=0.
- Opcode 0000000 -> NOP retire without the macro; with the macro, trap=1 and the FSM stays in TRAP until reset.
